cu_fsm_trap: RTL and testbench

// - Multicycle control-unit FSM for the RV32I OTTER core, parametrised successor of the current control FSM.
// - Adds configurable memory wait states, a SYSTEM opcode path (CSR writes, mret) and interrupt entry gated by mie.
// - Adds an optional illegal-opcode trap and corrects store sequencing (no RF write on stores).
// - Sits in otter top between the IR/CSR file and all datapath write/read enables.

---
 rtl/cu_fsm_pkg.sv | 61 ++++++
 rtl/cu_wait_ctr.sv | 26 ++
 rtl/cu_fsm_trap.sv | 119 +++++++++++
 tb/tb_cu_fsm_trap.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cu_fsm_pkg.sv
// Shared types and constants for the OTTER multicycle control unit.
//   state_t     : encoded FSM states (also exported on state_o for debug)
//   OP_*        : RV32I major opcodes recognised by the control unit
//   F3_PRIV     : SYSTEM funct3 selecting the privileged group (mret)
//   classify()  : folds opcode/funct3 into the control class used in EXEC
package cu_fsm_pkg;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_EXEC      = 3'd2,
        ST_LOAD_WAIT = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_INTR      = 3'd5
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    localparam logic [2:0] F3_PRIV   = 3'b000;
    // funct3 100 is unallocated in the SYSTEM space
    localparam logic [2:0] F3_SYS_RSVD = 3'b100;

    typedef enum logic [2:0] {
        CLS_ALU,      // result to RF, PC advances
        CLS_STORE,
        CLS_BRANCH,
        CLS_LOAD,
        CLS_MRET,
        CLS_CSR,
        CLS_ILLEGAL
    } op_class_t;

    function automatic op_class_t classify(input logic [6:0] opcode,
                                           input logic [2:0] funct3);
        op_class_t cls;
        case (opcode)
            OP_RTYPE, OP_ITYPE, OP_JALR,
            OP_LUI, OP_AUIPC, OP_JAL: cls = CLS_ALU;
            OP_STORE:                 cls = CLS_STORE;
            OP_BRANCH:                cls = CLS_BRANCH;
            OP_LOAD:                  cls = CLS_LOAD;
            OP_SYS: begin
                if (funct3 == F3_PRIV)          cls = CLS_MRET;
                else if (funct3 == F3_SYS_RSVD) cls = CLS_ILLEGAL;
                else                            cls = CLS_CSR;
            end
            default:                  cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/cu_wait_ctr.sv
// Wait-state counter for the control FSM.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (takes priority over en)
//   en         : count enable
//   limit      : number of cycles the owning state should last
//   done       : high in the last cycle of the wait (cnt+1 == limit)
module cu_wait_ctr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [3:0] limit,
    output logic       done
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   cnt <= 4'd0;
        else if (clr) cnt <= 4'd0;
        else if (en)  cnt <= cnt + 4'd1;
    end

    assign done = ((cnt + 4'd1) == limit);

endmodule

// File: rtl/cu_fsm_trap.sv
// Multicycle control FSM for the RV32I OTTER core with memory wait states,
// SYSTEM opcode handling (CSR writes, mret), mie-gated interrupt entry and
// an optional illegal-opcode trap.
//   clk, rst_n          : clock, async active-low reset
//   opcode, funct3      : IR fields decoded in EXEC
//   intr, mie           : interrupt request and global enable, sampled at
//                         instruction end only
//   PC_WE, RF_WE, mem_WE2, memRDEN1, memRDEN2, reset, csr_WE : datapath enables
//   int_taken, mret_exec: trap entry / trap return strobes
//   illegal             : unknown opcode seen in EXEC
//   state_o             : present state encoding (debug)
module cu_fsm_trap
    import cu_fsm_pkg::*;
#(
    parameter int FETCH_LAT    = 1,
    parameter int LOAD_LAT     = 1,
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       intr,
    input  logic       mie,
    output logic       PC_WE,
    output logic       RF_WE,
    output logic       mem_WE2,
    output logic       memRDEN1,
    output logic       memRDEN2,
    output logic       reset,
    output logic       csr_WE,
    output logic       int_taken,
    output logic       mret_exec,
    output logic       illegal,
    output logic [2:0] state_o
);

    localparam logic [3:0] FETCH_LIM = 4'(FETCH_LAT);
    // EXEC already supplies one memRDEN2 cycle, so LOAD_WAIT covers the rest
    localparam logic [3:0] LOAD_LIM  = 4'(LOAD_LAT - 1);

    state_t    state, nxt;
    op_class_t cls;
    logic      irq;
    logic      ctr_done;

    assign cls     = classify(opcode, funct3);
    assign irq     = intr & mie;
    assign state_o = state;

    cu_wait_ctr u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (nxt != state),
        .en    ((state == ST_FETCH) || (state == ST_LOAD_WAIT)),
        .limit ((state == ST_FETCH) ? FETCH_LIM : LOAD_LIM),
        .done  (ctr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_INIT;
        else        state <= nxt;
    end

    always_comb begin
        nxt = ST_INIT;
        case (state)
            ST_INIT:  nxt = ST_FETCH;
            ST_FETCH: nxt = ctr_done ? ST_EXEC : ST_FETCH;
            ST_EXEC: begin
                case (cls)
                    CLS_LOAD:    nxt = (LOAD_LAT == 1) ? ST_WRITEBACK : ST_LOAD_WAIT;
                    CLS_ILLEGAL: nxt = (ILLEGAL_TRAP != 0) ? ST_INTR : ST_INIT;
                    // mret with a pending enabled irq re-enters the trap at once;
                    // mie here is the pre-restore value from the CSR file
                    default:     nxt = irq ? ST_INTR : ST_FETCH;
                endcase
            end
            ST_LOAD_WAIT: nxt = ctr_done ? ST_WRITEBACK : ST_LOAD_WAIT;
            ST_WRITEBACK: nxt = irq ? ST_INTR : ST_FETCH;
            // always leave INTR through FETCH so entry can never nest
            ST_INTR:      nxt = ST_FETCH;
            default:      nxt = ST_INIT;
        endcase
    end

    always_comb begin
        PC_WE     = 1'b0;
        RF_WE     = 1'b0;
        mem_WE2   = 1'b0;
        memRDEN1  = 1'b0;
        memRDEN2  = 1'b0;
        reset     = 1'b0;
        csr_WE    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;
        illegal   = 1'b0;
        case (state)
            ST_INIT:  reset    = 1'b1;
            ST_FETCH: memRDEN1 = 1'b1;
            ST_EXEC: begin
                case (cls)
                    CLS_ALU:    begin PC_WE = 1'b1; RF_WE = 1'b1; end
                    CLS_STORE:  begin PC_WE = 1'b1; mem_WE2 = 1'b1; end
                    CLS_BRANCH: PC_WE = 1'b1;
                    CLS_LOAD:   memRDEN2 = 1'b1;
                    CLS_MRET:   begin PC_WE = 1'b1; mret_exec = 1'b1; end
                    CLS_CSR:    begin PC_WE = 1'b1; RF_WE = 1'b1; csr_WE = 1'b1; end
                    default:    illegal = 1'b1;
                endcase
            end
            ST_LOAD_WAIT: memRDEN2 = 1'b1;
            ST_WRITEBACK: begin PC_WE = 1'b1; RF_WE = 1'b1; end
            ST_INTR:      begin PC_WE = 1'b1; int_taken = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cu_fsm_trap.sv
// Bench for cu_fsm_trap. Two instances: u0 (FETCH_LAT=3, LOAD_LAT=4, trap on
// illegal) and u1 (FETCH_LAT=1, LOAD_LAT=1, illegal returns to INIT). The
// model expands each instruction into its list of expected cycles.
module tb_cu_fsm_trap;

    typedef struct packed {
        logic pc, rf, mw, rd1, rd2, rs, csr, itk, mret, ill;
        logic [2:0] st;
    } out_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        out_t       exp;   // expected outputs in the EXEC cycle
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [1:0][6:0] opcode;
    logic [1:0][2:0] funct3;
    logic [1:0]      intr, mie;
    logic [1:0]      pc_we, rf_we, mem_we2, rden1, rden2, rst_o, csr_we, int_taken, mret_exec, illegal;
    logic [1:0][2:0] state_o;

    cu_fsm_trap #(.FETCH_LAT(3), .LOAD_LAT(4), .ILLEGAL_TRAP(1)) u0 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode[0]), .funct3(funct3[0]),
        .intr(intr[0]), .mie(mie[0]), .PC_WE(pc_we[0]), .RF_WE(rf_we[0]),
        .mem_WE2(mem_we2[0]), .memRDEN1(rden1[0]), .memRDEN2(rden2[0]),
        .reset(rst_o[0]), .csr_WE(csr_we[0]), .int_taken(int_taken[0]),
        .mret_exec(mret_exec[0]), .illegal(illegal[0]), .state_o(state_o[0]));

    cu_fsm_trap #(.FETCH_LAT(1), .LOAD_LAT(1), .ILLEGAL_TRAP(0)) u1 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode[1]), .funct3(funct3[1]),
        .intr(intr[1]), .mie(mie[1]), .PC_WE(pc_we[1]), .RF_WE(rf_we[1]),
        .mem_WE2(mem_we2[1]), .memRDEN1(rden1[1]), .memRDEN2(rden2[1]),
        .reset(rst_o[1]), .csr_WE(csr_we[1]), .int_taken(int_taken[1]),
        .mret_exec(mret_exec[1]), .illegal(illegal[1]), .state_o(state_o[1]));

    int   tests = 0, fails = 0;
    vec_t tbl[$];
    out_t FETCH_V, WAIT_V, WB_V, INTR_V, INIT_V;
    logic [6:0] known_ops[10] = '{7'b0110011, 7'b0010011, 7'b1100111, 7'b0000011, 7'b0100011,
                                  7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011};

    function automatic int fl(int d); return (d == 0) ? 3 : 1; endfunction
    function automatic int ll(int d); return (d == 0) ? 4 : 1; endfunction
    function automatic bit it(int d); return (d == 0); endfunction

    function automatic out_t mk(logic pc, rf, mw, rd1, rd2, rs, csr, itk, mret, ill, logic [2:0] st);
        out_t r;
        r.pc = pc; r.rf = rf; r.mw = mw; r.rd1 = rd1; r.rd2 = rd2; r.rs = rs;
        r.csr = csr; r.itk = itk; r.mret = mret; r.ill = ill; r.st = st;
        return r;
    endfunction

    function automatic vec_t vx(logic [6:0] op, logic [2:0] f3,
                                logic pc, rf, mw, rd2, csr, mret, ill);
        vec_t v;
        v.op = op; v.f3 = f3;
        v.exp = mk(pc, rf, mw, 1'b0, rd2, 1'b0, csr, 1'b0, mret, ill, 3'd2);
        return v;
    endfunction

    function automatic out_t actual(int d);
        return mk(pc_we[d], rf_we[d], mem_we2[d], rden1[d], rden2[d], rst_o[d],
                  csr_we[d], int_taken[d], mret_exec[d], illegal[d], state_o[d]);
    endfunction

    function automatic bit is_known(logic [6:0] op);
        foreach (known_ops[i]) if (known_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(int d, out_t e, string nm);
        out_t a;
        a = actual(d);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s dut%0d t=%0t: got %b want %b", nm, d, $time, a, e);
        end
    endtask

    // mode 0: random irq inputs, 1: intr=mie=1, 2: intr=1 mie=0
    task automatic set_irq(int d, int mode);
        case (mode)
            1:       begin intr[d] = 1'b1; mie[d] = 1'b1; end
            2:       begin intr[d] = 1'b1; mie[d] = 1'b0; end
            default: begin intr[d] = 1'($urandom_range(0, 1)); mie[d] = 1'($urandom_range(0, 1)); end
        endcase
    endtask

    // One clock cycle: drive irq, check at negedge, optionally abort with reset.
    task automatic cyc(int d, out_t e, string nm, bit abort, int mode);
        set_irq(d, mode);
        @(negedge clk);
        chk(d, e, nm);
        if (abort) begin
            #1 rst_n = 1'b0;
            #1 chk(d, INIT_V, "async_reset");
            @(posedge clk); #1;
            chk(d, INIT_V, "reset_held");
            rst_n = 1'b1;
            @(negedge clk);
            chk(d, INIT_V, "init_after_release");
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        chk(0, INIT_V, "reset0");
        chk(1, INIT_V, "reset1");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk(0, INIT_V, "init0");
        chk(1, INIT_V, "init1");
        @(posedge clk); #1;
    endtask

    // Expected cycle list of one instruction starting at its first FETCH cycle.
    task automatic do_instr(int d, vec_t v, int mode, int abort_at);
        int k;
        bit irq;
        k = 0;
        opcode[d] = v.op;
        funct3[d] = v.f3;
        for (int i = 0; i < fl(d); i++) begin
            cyc(d, FETCH_V, "fetch", k == abort_at, mode);
            if (k == abort_at) return;
            k++;
        end
        cyc(d, v.exp, "exec", k == abort_at, mode);
        if (k == abort_at) return;
        k++;
        irq = intr[d] & mie[d];
        if (v.exp.ill) begin
            if (it(d)) cyc(d, INTR_V, "illegal_trap", 1'b0, mode);
            else       cyc(d, INIT_V, "illegal_init", 1'b0, mode);
            return;
        end
        if (v.exp.rd2) begin
            for (int i = 0; i < ll(d) - 1; i++) begin
                cyc(d, WAIT_V, "load_wait", k == abort_at, mode);
                if (k == abort_at) return;
                k++;
            end
            cyc(d, WB_V, "writeback", 1'b0, mode);
            irq = intr[d] & mie[d];
        end
        if (irq) cyc(d, INTR_V, "intr_entry", 1'b0, mode);
    endtask

    task automatic rand_instr(int d);
        vec_t v;
        logic [6:0] op;
        if ($urandom_range(0, 3) != 0) begin
            v = tbl[$urandom_range(0, tbl.size() - 1)];
            if (v.op != 7'b1110011) v.f3 = 3'($urandom_range(0, 7));
        end else begin
            do op = 7'($urandom_range(0, 127)); while (is_known(op));
            v = vx(op, 3'($urandom_range(0, 7)), 0, 0, 0, 0, 0, 0, 1);
        end
        do_instr(d, v, 0, -1);
    endtask

    initial begin
        vec_t add_v, lw_v, sw_v, csr_v, mret_v, bad_v;
        FETCH_V = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'd1);
        WAIT_V  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3'd3);
        WB_V    = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'd4);
        INTR_V  = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3'd5);
        INIT_V  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3'd0);

        //               op          f3    pc rf mw rd2 csr mret ill
        tbl.push_back(vx(7'b0110011, 3'd0, 1, 1, 0, 0, 0, 0, 0)); // add
        tbl.push_back(vx(7'b0010011, 3'd0, 1, 1, 0, 0, 0, 0, 0)); // addi
        tbl.push_back(vx(7'b1100111, 3'd0, 1, 1, 0, 0, 0, 0, 0)); // jalr
        tbl.push_back(vx(7'b0110111, 3'd0, 1, 1, 0, 0, 0, 0, 0)); // lui
        tbl.push_back(vx(7'b0010111, 3'd0, 1, 1, 0, 0, 0, 0, 0)); // auipc
        tbl.push_back(vx(7'b1101111, 3'd0, 1, 1, 0, 0, 0, 0, 0)); // jal
        tbl.push_back(vx(7'b0100011, 3'd2, 1, 0, 1, 0, 0, 0, 0)); // sw
        tbl.push_back(vx(7'b1100011, 3'd0, 1, 0, 0, 0, 0, 0, 0)); // beq
        tbl.push_back(vx(7'b0000011, 3'd2, 0, 0, 0, 1, 0, 0, 0)); // lw
        tbl.push_back(vx(7'b1110011, 3'd0, 1, 0, 0, 0, 0, 1, 0)); // mret
        tbl.push_back(vx(7'b1110011, 3'd1, 1, 1, 0, 0, 1, 0, 0)); // csrrw
        tbl.push_back(vx(7'b1110011, 3'd2, 1, 1, 0, 0, 1, 0, 0)); // csrrs
        tbl.push_back(vx(7'b1110011, 3'd3, 1, 1, 0, 0, 1, 0, 0)); // csrrc
        tbl.push_back(vx(7'b1110011, 3'd5, 1, 1, 0, 0, 1, 0, 0)); // csrrwi
        tbl.push_back(vx(7'b1110011, 3'd6, 1, 1, 0, 0, 1, 0, 0)); // csrrsi
        tbl.push_back(vx(7'b1110011, 3'd7, 1, 1, 0, 0, 1, 0, 0)); // csrrci
        tbl.push_back(vx(7'b1110011, 3'd4, 0, 0, 0, 0, 0, 0, 1)); // sys f3=100
        tbl.push_back(vx(7'b1111111, 3'd0, 0, 0, 0, 0, 0, 0, 1)); // unknown
        tbl.push_back(vx(7'b0000000, 3'd0, 0, 0, 0, 0, 0, 0, 1)); // unknown

        add_v  = tbl[0];
        sw_v   = tbl[6];
        lw_v   = tbl[8];
        mret_v = tbl[9];
        csr_v  = tbl[10];
        bad_v  = tbl[17];

        opcode = '0; funct3 = '0; intr = '0; mie = '0;
        do_reset();

        // u0: directed corner cases
        do_instr(0, add_v,  2, -1);
        do_instr(0, lw_v,   2, -1);
        do_instr(0, sw_v,   2, -1);
        do_instr(0, csr_v,  2, -1);
        do_instr(0, lw_v,   1, -1);  // irq pending from FETCH: waits for WRITEBACK
        do_instr(0, add_v,  2, -1);  // INTR was one cycle, now fetching normally
        do_instr(0, mret_v, 1, -1);  // mret completes, then INTR
        do_instr(0, bad_v,  2, -1);  // illegal -> INTR
        do_instr(0, add_v,  0, 3);   // reset during EXEC
        do_instr(0, lw_v,   0, 5);   // reset during LOAD_WAIT
        do_instr(0, add_v,  2, -1);
        foreach (tbl[i]) do_instr(0, tbl[i], 0, -1);
        for (int i = 0; i < 200; i++) rand_instr(0);

        // u1: single-cycle latencies, illegal returns through INIT
        do_reset();
        do_instr(1, bad_v, 1, -1);
        do_instr(1, lw_v,  1, -1);
        do_instr(1, lw_v,  2, -1);
        foreach (tbl[i]) do_instr(1, tbl[i], 0, -1);
        for (int i = 0; i < 200; i++) rand_instr(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
